multicycle_controller: RTL

Control unit for the multicycle MIPS core: a Moore-style main FSM plus a combinational ALU decoder that sequences the shared-ALU, single-memory datapath one instruction at a time. It consumes `op`, `funct` and `zero` from the datapath. It drives every datapath enable and mux select, plus the memory write strobe. It sits beside the datapath inside the processor top level.

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle MIPS core: Moore main FSM sequencing the
// shared-ALU datapath, plus a combinational ALU decoder.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned ALUC_W  = 3;

  localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
  localparam logic [STATE_W-1:0] S_RTYPEEX = 4'd6;
  localparam logic [STATE_W-1:0] S_RTYPEWB = 4'd7;
  localparam logic [STATE_W-1:0] S_BEQEX   = 4'd8;
  localparam logic [STATE_W-1:0] S_ADDIEX  = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIWB  = 4'd10;
  localparam logic [STATE_W-1:0] S_JEX     = 4'd11;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic               pcwrite;
  logic               branch;
  logic [ALUOP_W-1:0] aluop;
  logic               irwrite_s;
  logic               regwrite_s;
  logic               memwrite_s;

  // State register; reset lands in FETCH so the first released edge fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; illegal encodings and unknown opcodes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode of the current state.
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        alusrcb = 2'b00;
      end
    endcase
  end

  // ALU decoder; unrecognised funct codes fall back to add.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

  // Write enables are held off for the whole time reset is low.
  assign pcen     = (pcwrite | (branch & zero)) & reset;
  assign irwrite  = irwrite_s & reset;
  assign regwrite = regwrite_s & reset;
  assign memwrite = memwrite_s & reset;
  assign state    = state_q;

endmodule
